// File: rtl/shared_resource_scheduler.sv
// rtl/shared_resource_scheduler.sv - round-robin owner of the shared resource between pipelines 1 and 2
// Optional hold-limit preemption is compiled in with `define HOLD_LIMIT_EN.
module shared_resource_scheduler #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_1_i,
  input  logic req_2_i,
  output logic grant_1_o,
  output logic grant_2_o,
  output logic resource_sel_o,
  output logic preempt_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_1 = 2'd1,
    OWN_2 = 2'd2
  } state_e;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("shared_resource_scheduler: MAX_HOLD must be at least 1");
  end

  state_e state_q, state_d;
  logic   grant_1_q, grant_1_d;
  logic   grant_2_q, grant_2_d;
  logic   sel_q, sel_d;
  logic   preempt_q, preempt_d;
  // 0 = pipeline 1 was granted last, 1 = pipeline 2 was granted last
  logic   last_owner_q, last_owner_d;
  logic   limit_hit_1, limit_hit_2;

`ifdef HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Preemption fires only when the counter has reached its last slot and the other side waits.
  assign limit_hit_1 = (hold_cnt_q == HOLD_LAST) && req_2_i;
  assign limit_hit_2 = (hold_cnt_q == HOLD_LAST) && req_1_i;
`else
  assign limit_hit_1 = 1'b0;
  assign limit_hit_2 = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_1_d    = grant_1_q;
    grant_2_d    = grant_2_q;
    sel_d        = sel_q;
    preempt_d    = 1'b0;
    last_owner_d = last_owner_q;
`ifdef HOLD_LIMIT_EN
    hold_cnt_d   = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_1_i && (!req_2_i || last_owner_q)) begin
          state_d      = OWN_1;
          grant_1_d    = 1'b1;
          sel_d        = 1'b0;
          last_owner_d = 1'b0;
`ifdef HOLD_LIMIT_EN
          hold_cnt_d   = '0;
`endif
        end else if (req_2_i) begin
          state_d      = OWN_2;
          grant_2_d    = 1'b1;
          sel_d        = 1'b1;
          last_owner_d = 1'b1;
`ifdef HOLD_LIMIT_EN
          hold_cnt_d   = '0;
`endif
        end
      end
      OWN_1: begin
        if (!req_1_i) begin
          state_d   = IDLE;
          grant_1_d = 1'b0;
        end else if (limit_hit_1) begin
          state_d   = IDLE;
          grant_1_d = 1'b0;
          preempt_d = 1'b1;
        end else begin
`ifdef HOLD_LIMIT_EN
          if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + CNT_W'(1);
`endif
        end
      end
      OWN_2: begin
        if (!req_2_i) begin
          state_d   = IDLE;
          grant_2_d = 1'b0;
        end else if (limit_hit_2) begin
          state_d   = IDLE;
          grant_2_d = 1'b0;
          preempt_d = 1'b1;
        end else begin
`ifdef HOLD_LIMIT_EN
          if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        grant_1_d = 1'b0;
        grant_2_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_1_q    <= 1'b0;
      grant_2_q    <= 1'b0;
      sel_q        <= 1'b0;
      preempt_q    <= 1'b0;
      last_owner_q <= 1'b1;
`ifdef HOLD_LIMIT_EN
      hold_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_1_q    <= grant_1_d;
      grant_2_q    <= grant_2_d;
      sel_q        <= sel_d;
      preempt_q    <= preempt_d;
      last_owner_q <= last_owner_d;
`ifdef HOLD_LIMIT_EN
      hold_cnt_q   <= hold_cnt_d;
`endif
    end
  end

  assign grant_1_o      = grant_1_q;
  assign grant_2_o      = grant_2_q;
  assign resource_sel_o = sel_q;
  assign preempt_o      = preempt_q;
  assign busy_o         = grant_1_q | grant_2_q;

endmodule

// File: tb/tb_shared_resource_scheduler.sv
// tb/tb_shared_resource_scheduler.sv - scoreboard bench for shared_resource_scheduler
module tb_shared_resource_scheduler;

  logic clk;
  logic reset;
  logic req_1, req_2;
  logic grant_1, grant_2, resource_sel, preempt, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  // expected {grant_1, grant_2, resource_sel, preempt, busy} for the cycle after the next edge
  logic [4:0] exp_q[$];

  shared_resource_scheduler #(.MAX_HOLD(4)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_1_i        (req_1),
    .req_2_i        (req_2),
    .grant_1_o      (grant_1),
    .grant_2_o      (grant_2),
    .resource_sel_o (resource_sel),
    .preempt_o      (preempt),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {grant_1, grant_2, resource_sel, preempt, busy};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got g1g2 sel pre busy=%b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r1, input logic r2, input logic g1, input logic g2,
                      input logic sel, input logic pre);
    @(negedge clk);
    req_1 = r1;
    req_2 = r2;
    exp_q.push_back({g1, g2, sel, pre, g1 | g2});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    reset = 1'b1;
    req_1 = 1'b0;
    req_2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation.
  initial begin
    logic [4:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cycle", outs(), e);
        chk("exclusive", {4'b0, grant_1 & grant_2}, 5'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_1 = 1'b0;
    req_2 = 1'b0;
    #1;
    chk("reset_values", outs(), 5'b00000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // single requester, then release with resource_sel held
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // tie after reset goes to pipeline 1, handover through one idle cycle
    do_reset();
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // owner releases in the very cycle the limit would have fired: no preempt
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);

`ifdef HOLD_LIMIT_EN
    // both held high with MAX_HOLD = 4: 4 grants, preempt, 4 grants, preempt ...
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) step(1, 1, p[0] == 1'b0, p[0] == 1'b1, p[0] == 1'b1, 0);
      step(1, 1, 0, 0, p[0] == 1'b1, 1);
    end
    step(0, 0, 0, 0, 0, 0);
`else
    // without the limit the first owner keeps the resource indefinitely
    do_reset();
    for (int i = 0; i < 100; i++) step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`endif

    // asynchronous reset while pipeline 2 owns the resource
    do_reset();
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    drain();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_grant_2", {1'b0, grant_2, 3'b0}, 5'b0);
    chk("async_reset_outputs", outs(), 5'b00000);
    req_1 = 1'b1;
    req_2 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(5'b10001);
    step(0, 0, 0, 0, 0, 0);
    drain();

    done = 1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
